// File: rtl/ysyx_220053_wb_arbiter.sv
// Register-file write-port arbiter: LSU load results vs. FIFO-buffered ALU results, registered output stage.
// Optional forwarding lookup over buffered/in-flight writes is enabled by defining YSYX_220053_WB_FWD_EN.
module ysyx_220053_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_W-1:0]        lsu_rd,
  input  logic [DATA_W-1:0]        lsu_data,
  output logic                     rf_wen,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     pending,
  output logic [$clog2(DEPTH):0]   fifo_cnt
`ifdef YSYX_220053_WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]        fwd_rs,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              full, empty, push, pop, sel_vld;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign alu_ready = !full;
  assign push      = alu_valid && alu_ready;

  // LSU wins unless the FIFO is full; a full FIFO retires its head so the ALU never deadlocks.
  always_comb begin
    lsu_ready = 1'b0;
    pop       = 1'b0;
    sel_vld   = 1'b0;
    sel_rd    = rd_mem_q[rd_ptr_q];
    sel_data  = data_mem_q[rd_ptr_q];
    if (lsu_valid && !full) begin
      lsu_ready = 1'b1;
      sel_vld   = 1'b1;
      sel_rd    = lsu_rd;
      sel_data  = lsu_data;
    end else if (!empty) begin
      pop     = 1'b1;
      sel_vld = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    // x0 writes still consume their slot but never raise the enable.
    wen_d    = sel_vld && (sel_rd != '0);
    waddr_d  = sel_vld ? sel_rd   : waddr_q;
    wdata_d  = sel_vld ? sel_data : wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= alu_rd;
      data_mem_q[wr_ptr_q] <= alu_data;
    end
  end

  assign rf_wen   = wen_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign fifo_cnt = cnt_q;
  assign pending  = !empty || wen_q;

`ifdef YSYX_220053_WB_FWD_EN
  // Lowest priority first so later (newer) matches override earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_rs != '0) begin
      if (wen_q && (waddr_q == fwd_rs)) begin
        fwd_hit  = 1'b1;
        fwd_data = wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < cnt_q) && (rd_mem_q[rd_ptr_q + PW'(i)] == fwd_rs)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_mem_q[rd_ptr_q + PW'(i)];
        end
      end
    end
  end
`endif

endmodule

// File: doc/ysyx_220053_wb_arbiter.md
Name: ysyx_220053_wb_arbiter

Overview:
- Sequences and shares the single register-file write port between two producers.
  - ALU results: fixed 1-cycle source.
  - LSU load results: variable-latency source.
- ALU writes are buffered in a small FIFO so the ALU is not stalled by a concurrent load return.
- Sits between EXU/LSU and the register file. Drives its wen/waddr/wdata through a registered output stage.

Parameters:
- ADDR_W, 5, register index width
- DATA_W, 64, write data width
- DEPTH, 2, ALU write FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU write request
- alu_ready  out  1  FIFO can accept ALU write
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- lsu_valid  in  1  load result valid
- lsu_ready  out  1  load result accepted this cycle
- lsu_rd  in  ADDR_W  load destination register
- lsu_data  in  DATA_W  load data
- rf_wen  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  write address (registered)
- rf_wdata  out  DATA_W  write data (registered)
- pending  out  1  any write not yet retired (FIFO non-empty or rf_wen)
- fifo_cnt  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset:
  - Clock is clk; reset is rst_n, asynchronous, active-low.
  - rst_n low immediately clears FIFO pointers/count, rf_wen=0, rf_waddr=0, rf_wdata=0, pending=0, fifo_cnt=0.
  - Reset mid-operation discards all buffered writes. No write is issued on the cycle rst_n deasserts.
- ALU handshake:
  - alu_ready = (fifo_cnt < DEPTH); combinational from count only, never from pop.
  - Push when alu_valid && alu_ready.
- Selection each cycle (combinational, result registered at edge):
  - Case A, lsu_valid && fifo_cnt<DEPTH: LSU wins, lsu_ready=1, FIFO head not popped.
  - Case B, lsu_valid && FIFO full: FIFO head wins (pop), lsu_ready=0. This is starvation guard; LSU must hold its request.
  - Case C, !lsu_valid && FIFO non-empty: pop head.
  - Case D, none of the above: rf_wen<=0 next cycle; rf_waddr/rf_wdata hold previous values.
- Output stage:
  - Selected entry registered into rf_waddr/rf_wdata.
  - rf_wen<=1 unless selected rd==0, in which case rf_wen<=0 (x0 writes consumed silently).
- Latency:
  - LSU accept to rf_wen: 1 cycle.
  - ALU push to rf_wen, uncontested: 2 cycles (push at edge N, pop/register at N+1). No FIFO bypass.
- Simultaneous events:
  - Push and pop in the same cycle leave fifo_cnt unchanged. Pointers wrap modulo DEPTH.
  - Push while full cannot occur (alu_ready=0).
- Ordering:
  - FIFO is strictly in order among ALU writes.
  - No ordering is enforced between ALU and LSU writes to the same rd. Issue logic uses pending to stall.
- pending:
  - Equals (fifo_cnt!=0) || rf_wen.
  - Deasserts the cycle after the final write is presented.

Optional Feature:
- Macro: YSYX_220053_WB_FWD_EN.
- When defined, adds ports:
  - fwd_rs in ADDR_W
  - fwd_hit out 1
  - fwd_data out DATA_W
- Forwarding lookup, combinational:
  - Search priority: newest FIFO entry first, then oldest, then the output register (when rf_wen=1).
  - fwd_hit=1 on match with fwd_rs!=0.
  - fwd_data is the matched data, else 0.
- When undefined, the ports are absent and no comparators are instantiated.

Test Plan:
- Reset: hold rst_n=0 with alu_valid=1 -> rf_wen=0, alu_ready=1, fifo_cnt=0, pending=0. Release: first write appears exactly 2 cycles after first push.
- ALU only: push rd=3 data=0x10, then rd=4 data=0x20 on consecutive cycles -> rf_wen=1 at cycles +2 and +3 with (3,0x10), (4,0x20), in order. pending falls after.
- Contention: FIFO holds 1 entry (rd=5), lsu_valid with rd=6 data=0xAA -> LSU written first (lsu_ready=1), then rd=5 the following cycle.
- Starvation guard: fill FIFO (DEPTH=2), hold lsu_valid -> lsu_ready=0 for 1 cycle, head retires, then lsu_ready=1. alu_ready=0 while full.
- x0: push alu_rd=0 data=0xFFFF -> FIFO pops, rf_wen stays 0, fifo_cnt returns to 0.
- Reset mid-flight: FIFO full, assert rst_n low asynchronously mid-cycle -> outputs clear immediately. No buffered write appears after release.
